serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin one subtraction; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  minuend, unsigned; sampled only on the edge where start is accepted.
REQ-006 Port: b  input  WIDTH  subtrahend, unsigned; sampled only on the edge where start is accepted.
REQ-007 Port: ready  output  1  high only in IDLE; start is accepted only when ready=1.
REQ-008 Port: busy  output  1  high only in RUN.
REQ-009 Port: done  output  1  single-cycle pulse, high only in DONE.
REQ-010 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH; valid from done onward and held until the next completion.
REQ-011 Port: borrow  output  1  final borrow-out, 1 when a<b; updated and held with diff.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 IDLE SHALL move to RUN on an edge with start=1, latching a and b into internal shift registers, clearing the borrow register to 0 and clearing the bit counter to 0.
REQ-014 IDLE with start=0 SHALL stay in IDLE.
REQ-015 Each RUN edge SHALL process one bit LSB-first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 Each d_i SHALL be shifted into the result register so that d_0 finally lands at diff[0].
REQ-017 The bit counter SHALL increment once per RUN edge and SHALL be $clog2(WIDTH)+1 bits wide so that it cannot wrap.
REQ-018 On the RUN edge that processes bit WIDTH-1, the FSM SHALL move to DONE and SHALL load diff and borrow from the final values.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-021 Minimum issue interval SHALL be WIDTH+2 cycles.
REQ-022 start asserted in RUN or DONE SHALL be ignored: no effect on operands, counter or outputs, and the request is not queued.
REQ-023 Changes on a or b after the accepting edge SHALL NOT affect the in-flight result.
REQ-024 diff and borrow SHALL change only on the DONE-entry edge or on reset.
REQ-025 ready, busy and done SHALL be registered or decoded directly from the state register, with exactly one of them high at any time.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, ready=1, busy=0, done=0, diff=0, borrow=0, and clear the counter, borrow register and shift registers.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation, suppress any pending done pulse and leave diff/borrow at 0.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification (WIDTH=8)
REQ-029 Scenario: a=0x5A, b=0x33, start pulse -> done in cycle after edge k+8; diff=0x27, borrow=0.
REQ-030 Scenario: a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF -> diff=0x00, borrow=0.
REQ-031 Scenario: start and a=0x10, b=0x20 asserted 3 cycles into a 0x80-0x01 run -> first result diff=0x7F, borrow=0 delivered; no second done pulse.
REQ-032 Scenario: rst_n pulsed low at RUN bit 4 of 0x5A-0x33 -> outputs immediately 0/ready=1, no done pulse; a new run of 0x01-0x02 then gives diff=0xFF, borrow=1.
REQ-033 Scenario: start held high continuously -> a done pulse every 10 cycles, each carrying the operands present on its accepting edge.
REQ-034 Scenario: random a/b for 1000 operations -> diff equals (a-b) mod 256 and borrow equals (a<b) in every case; ready, busy and done are one-hot in every cycle.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first.
// A start in IDLE launches a WIDTH-cycle run, then a one-cycle DONE pulse.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // One extra counter bit so the count can never wrap back to zero.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;

  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Full-subtractor slice on the current LSBs of the operand shifters.
  assign bit_d    = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
  assign res_next = {bit_d, res_reg[WIDTH-1:1]};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RUN;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= res_next;
          br_reg  <= br_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            diff      <= res_next;
            borrow    <= br_next;
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          ready     <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: cycle-index reference model plus
// directed literal scenarios and randomized traffic.
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int tests = 0;
  int fails = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted operation occupies edges acc..acc+W+1,
  // its result appears after edge acc+W and is then held.
  bit           m_active = 1'b0;
  int           m_edge = 0;
  int           m_acc = 0;
  int           m_accepts = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_diff = '0;
  bit           m_borrow = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_edge   = 0;
      m_acc    = 0;
      m_diff   = '0;
      m_borrow = 1'b0;
    end else begin
      m_edge++;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_acc    = m_edge;
          m_a      = a;
          m_b      = b;
          m_accepts++;
        end
      end else if (m_edge == m_acc + W) begin
        m_diff   = m_a - m_b;
        m_borrow = (m_a < m_b);
      end else if (m_edge == m_acc + W + 1) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic e_done;
    e_done = m_active && (m_edge == m_acc + W);
    chk("ready", {31'b0, ready}, {31'b0, !m_active});
    chk("busy", {31'b0, busy}, {31'b0, m_active && !e_done});
    chk("done", {31'b0, done}, {31'b0, e_done});
    chk("diff", {24'b0, diff}, {24'b0, m_diff});
    chk("borrow", {31'b0, borrow}, {31'b0, m_borrow});
    chk("onehot", 32'(ready) + 32'(busy) + 32'(done), 32'd1);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input logic [W-1:0] ed, input logic eb);
    int lat;
    wait_idle();
    start = 1'b1;
    a = ra;
    b = rb;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("[TB] op %02h-%02h: diff=%02h borrow=%0d latency=%0d", ra, rb, diff, borrow, lat);
    chk("latency", 32'(lat), 32'(W + 1));
    chk("lit_diff", {24'b0, diff}, {24'b0, ed});
    chk("lit_borrow", {31'b0, borrow}, {31'b0, eb});
  endtask

  initial begin
    int dones;
    int last_done;
    int cyc;
    int base;
    logic [W-1:0] got;
    logic gb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_diff", {24'b0, diff}, 32'd0);
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
    rst_n = 1'b1;

    // Basic results, first one launched right after reset release
    run_op(8'h5A, 8'h33, 8'h27, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0);

    // start during RUN is ignored and not queued
    wait_idle();
    start = 1'b1;
    a = 8'h80;
    b = 8'h01;
    dones = 0;
    got = '0;
    gb = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = (i >= 3 && i <= 5);
      if (start) begin
        a = 8'h10;
        b = 8'h20;
      end
      if (done) begin
        dones++;
        got = diff;
        gb = borrow;
      end
    end
    $display("[TB] ignored-start run: dones=%0d diff=%02h borrow=%0d", dones, got, gb);
    chk("ign_dones", 32'(dones), 32'd1);
    chk("ign_diff", {24'b0, got}, 32'h7F);
    chk("ign_borrow", {31'b0, gb}, 32'd0);

    // Asynchronous abort during RUN
    wait_idle();
    start = 1'b1;
    a = 8'h5A;
    b = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] abort: ready=%0d busy=%0d done=%0d diff=%02h borrow=%0d", ready, busy, done, diff, borrow);
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_diff", {24'b0, diff}, 32'd0);
    chk("abort_borrow", {31'b0, borrow}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_nodone", 32'(dones), 32'd0);
    run_op(8'h01, 8'h02, 8'hFF, 1'b1);

    // start held high: back-to-back ops every W+2 cycles
    wait_idle();
    start = 1'b1;
    dones = 0;
    last_done = -1;
    for (int i = 0; i < 62; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      if (done) begin
        $display("[TB] held-start done at cycle %0d diff=%02h borrow=%0d", i, diff, borrow);
        if (last_done >= 0) chk("interval", 32'(i - last_done), 32'(W + 2));
        last_done = i;
        dones++;
      end
    end
    start = 1'b0;
    chk("held_dones", 32'(dones), 32'd6);

    // Randomized traffic, 1000 accepted operations
    base = m_accepts;
    cyc = 0;
    while ((m_accepts - base) < 1000 && cyc < 30000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      b = W'($urandom);
      if (done) $display("[TB] rand op %0d: diff=%02h borrow=%0d", m_accepts - base, diff, borrow);
      cyc++;
    end
    start = 1'b0;
    chk("rand_count", {31'b0, (m_accepts - base) >= 1000}, 32'd1);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
